rf_wport_arbiter: RTL and testbench

Controller for the single register-file write port. After reset it sequences a zero-clear of registers 1..NUM_REGS-1. It then shares the port between three writers: the pipeline writeback stage (fixed top priority, no backpressure), the long-latency unit (divider/memory return) and the debug port, both with valid/ready handshakes. A starvation counter requests a pipeline writeback bubble when the shared port is monopolised. Sits between the writeback stage, the LLU, the debug interface and the register file write port (we, w_addr, w_data).

---
 rtl/rf_wport_arbiter.sv | 150 +++++++++++++++
 tb/tb_rf_wport_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wport_arbiter
//
// Owns the single register-file write port.
//   * Out of reset it walks registers 1..NUM_REGS-1 writing zero (CLEAR).
//   * In RUN it shares the port between three writers:
//       - pipeline writeback (wb_*): top priority, no handshake
//       - long-latency unit (lu_*): valid/ready
//       - debug port (dbg_*): valid/ready
//     LLU and debug are arbitrated round-robin whenever writeback leaves the
//     port free.
//   * A starvation counter raises stall_req so the pipeline inserts a
//     writeback bubble when LLU/debug have been locked out for too long.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   wb_we/wb_addr/wb_data     pipeline writeback request
//   lu_valid/lu_addr/lu_data  LLU request, lu_ready = accepted this cycle
//   dbg_valid/dbg_addr/...    debug request, dbg_ready = accepted this cycle
//   rf_we/rf_w_addr/rf_w_data register file write port
//   init_busy                 clear sequence in progress
//   stall_req                 ask the pipeline to hold wb_we low
//
// The grant path is purely combinational so the register file's same-cycle
// read bypass sees the data being written.
// -----------------------------------------------------------------------------
module rf_wport_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_REGS   = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    input  logic              dbg_valid,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    output logic              init_busy,
    output logic              stall_req
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0]  LIM_C    = CNT_W'(STARVE_LIM);
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;
    // rr_ptr_reg: 0 = LLU preferred on a tie, 1 = debug preferred on a tie
    logic              rr_ptr_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;

    logic wb_occ;
    logic port_free;
    logic lu_grant;
    logic dbg_grant;

    // A writeback to r0 is a no-op and leaves the port to the other writers.
    assign wb_occ    = wb_we && (wb_addr != '0);
    assign port_free = !rst && (state_reg == RUN) && !wb_occ;
    assign lu_grant  = port_free && lu_valid  && (!dbg_valid || !rr_ptr_reg);
    assign dbg_grant = port_free && dbg_valid && (!lu_valid  ||  rr_ptr_reg);

    assign lu_ready  = lu_grant;
    assign dbg_ready = dbg_grant;
    assign init_busy = rst || (state_reg == CLEAR);
    assign stall_req = !rst && (state_reg == RUN) && (wait_cnt_reg >= LIM_C);

    always_comb begin
        rf_we     = 1'b0;
        rf_w_addr = '0;
        rf_w_data = '0;
        if (!rst) begin
            if (wb_occ) begin
                // Writeback wins even during CLEAR or while stall_req is up.
                rf_we     = 1'b1;
                rf_w_addr = wb_addr;
                rf_w_data = wb_data;
            end else if (state_reg == CLEAR) begin
                rf_we     = 1'b1;
                rf_w_addr = clr_cnt_reg;
            end else if (lu_grant) begin
                // r0 requests are accepted but never reach the file.
                rf_we     = (lu_addr != '0);
                rf_w_addr = lu_addr;
                rf_w_data = lu_data;
            end else if (dbg_grant) begin
                rf_we     = (dbg_addr != '0);
                rf_w_addr = dbg_addr;
                rf_w_data = dbg_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= CLEAR;
            clr_cnt_reg  <= ADDR_W'(1);
            rr_ptr_reg   <= 1'b0;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    // A stray writeback steals the port; the clear step waits.
                    if (!wb_occ) begin
                        if (clr_cnt_reg == LAST_REG) begin
                            state_reg <= RUN;
                        end else begin
                            clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (lu_grant) begin
                        rr_ptr_reg <= 1'b1;
                    end else if (dbg_grant) begin
                        rr_ptr_reg <= 1'b0;
                    end

                    if (lu_grant || dbg_grant) begin
                        wait_cnt_reg <= '0;
                    end else if (lu_valid || dbg_valid) begin
                        if (wait_cnt_reg < LIM_C) begin
                            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        wait_cnt_reg <= '0;
                    end
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wport_arbiter
//
// Directed scenarios followed by a randomized phase. Every cycle the full set
// of DUT outputs is compared against a behavioural model that tracks the
// clear progress, which requester won last, and how many cycles the
// LLU/debug side has been kept waiting.
// -----------------------------------------------------------------------------
module tb_rf_wport_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int NUM_REGS   = 32;
    localparam int STARVE_LIM = 4;
    localparam int VW         = ADDR_W + DATA_W + 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              lu_valid;
    logic [ADDR_W-1:0] lu_addr;
    logic [DATA_W-1:0] lu_data;
    logic              lu_ready;
    logic              dbg_valid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_w_addr;
    logic [DATA_W-1:0] rf_w_data;
    logic              init_busy;
    logic              stall_req;

    rf_wport_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .lu_valid (lu_valid),
        .lu_addr  (lu_addr),
        .lu_data  (lu_data),
        .lu_ready (lu_ready),
        .dbg_valid(dbg_valid),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .dbg_ready(dbg_ready),
        .rf_we    (rf_we),
        .rf_w_addr(rf_w_addr),
        .rf_w_data(rf_w_data),
        .init_busy(init_busy),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_clearing   = 1'b1;
    int m_next_reg   = 1;
    int m_last_win   = 1;      // 0 = LLU won last, 1 = debug won last
    int m_denied     = 0;
    bit e_lu_ready;
    bit e_dbg_ready;

    function automatic logic [VW-1:0] pack(input logic we, input logic [ADDR_W-1:0] a,
                                           input logic [DATA_W-1:0] d, input logic lr,
                                           input logic dr, input logic ib, input logic st);
        return {we, a, d, lr, dr, ib, st};
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_stall();
        return !m_clearing && (m_denied >= STARVE_LIM);
    endfunction

    // Evaluate the model for the current inputs, compare, then advance a cycle.
    task automatic tick(input string tag);
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bit lr, dr, ib, st;
        bit n_clearing;
        int n_next, n_last, n_denied;
        int winner;
        #2;
        we = 1'b0; a = '0; d = '0; lr = 1'b0; dr = 1'b0;
        n_clearing = m_clearing; n_next = m_next_reg;
        n_last = m_last_win;     n_denied = m_denied;
        if (rst) begin
            ib = 1'b1; st = 1'b0;
            n_clearing = 1'b1; n_next = 1; n_last = 1; n_denied = 0;
        end else begin
            ib = m_clearing;
            st = model_stall();
            if (wb_we && wb_addr != 0) begin
                we = 1'b1; a = wb_addr; d = wb_data;
                if (!m_clearing)
                    n_denied = (lu_valid || dbg_valid) ?
                               ((m_denied + 1 > STARVE_LIM) ? STARVE_LIM : m_denied + 1) : 0;
            end else if (m_clearing) begin
                we = 1'b1; a = ADDR_W'(m_next_reg);
                if (m_next_reg == NUM_REGS - 1) n_clearing = 1'b0;
                else                            n_next = m_next_reg + 1;
            end else begin
                winner = -1;
                if (lu_valid && dbg_valid) winner = 1 - m_last_win;
                else if (lu_valid)         winner = 0;
                else if (dbg_valid)        winner = 1;
                if (winner == 0) begin
                    lr = 1'b1; a = lu_addr; d = lu_data; we = (lu_addr != 0);
                end else if (winner == 1) begin
                    dr = 1'b1; a = dbg_addr; d = dbg_data; we = (dbg_addr != 0);
                end
                if (winner >= 0) n_last = winner;
                n_denied = 0;
            end
        end
        e_lu_ready  = lr;
        e_dbg_ready = dr;
        chk(tag, pack(rf_we, rf_w_addr, rf_w_data, lu_ready, dbg_ready, init_busy, stall_req),
                 pack(we, a, d, lr, dr, ib, st));
        @(posedge clk);
        m_clearing = n_clearing; m_next_reg = n_next;
        m_last_win = n_last;     m_denied = n_denied;
        @(negedge clk);
    endtask

    task automatic idle();
        wb_we = 1'b0;  wb_addr = '0;  wb_data = '0;
        lu_valid = 1'b0;  lu_addr = '0;  lu_data = '0;
        dbg_valid = 1'b0; dbg_addr = '0; dbg_data = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        tick("reset");
        tick("reset");

        // Clear sequence after reset release
        rst = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            #1 chk("clear_step", VW'({rf_we, rf_w_addr, rf_w_data, init_busy}),
                   VW'({1'b1, ADDR_W'(i), {DATA_W{1'b0}}, 1'b1}));
            tick("clear");
        end
        #1 chk("run_entry", VW'({init_busy, rf_we}), VW'(2'b00));
        tick("run_idle");

        // Writeback beats a pending LLU request
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h0000A5A5;
        #1 chk("wb_priority", VW'({rf_we, rf_w_addr, rf_w_data, lu_ready}),
               VW'({1'b1, 5'd5, 32'hDEADBEEF, 1'b0}));
        tick("wb_priority");
        wb_we = 1'b0;
        #1 chk("lu_after_wb", VW'({lu_ready, rf_w_addr, rf_w_data}),
               VW'({1'b1, 5'd3, 32'h0000A5A5}));
        tick("lu_after_wb");
        idle();

        // Round-robin with both held high; LLU won last, so debug goes first
        lu_valid = 1'b1;  lu_addr = 5'd10;  lu_data = 32'h1;
        dbg_valid = 1'b1; dbg_addr = 5'd11; dbg_data = 32'h2;
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_alternate", VW'({lu_ready, dbg_ready}),
                   VW'((k % 2 == 0) ? 2'b01 : 2'b10));
            tick("rr");
        end
        idle();

        // Starvation: four denied cycles raise stall_req
        lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'h77;
        for (int i = 0; i < STARVE_LIM; i++) begin
            wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'(i);
            #1 chk("starve_pre", VW'({stall_req, lu_ready}), VW'(2'b00));
            tick("starve");
        end
        wb_we = 1'b0;
        #1 chk("starve_stall", VW'({stall_req, lu_ready}), VW'(2'b11));
        tick("starve_grant");
        lu_valid = 1'b0;
        #1 chk("stall_drop", VW'(stall_req), VW'(1'b0));
        tick("stall_drop");
        idle();

        // wb to r0 leaves the port free; r0 LLU request accepted without a write
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
        dbg_valid = 1'b1; dbg_addr = 5'd7; dbg_data = 32'h1234;
        #1 chk("wb_r0_dbg", VW'({dbg_ready, rf_we, rf_w_addr, rf_w_data}),
               VW'({1'b1, 1'b1, 5'd7, 32'h1234}));
        tick("wb_r0_dbg");
        idle();
        lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'h55;
        #1 chk("lu_r0", VW'({lu_ready, rf_we}), VW'(2'b10));
        tick("lu_r0");
        idle();

        // Reset at clear step 10 restarts the sweep at reg 1
        rst = 1'b1; tick("reset");
        rst = 1'b0;
        for (int i = 1; i < 10; i++) tick("clear");
        rst = 1'b1;
        #1 chk("mid_clear_rst", VW'({rf_we, init_busy}), VW'(2'b01));
        tick("mid_clear_rst");
        rst = 1'b0;
        #1 chk("clear_restart", VW'({rf_we, rf_w_addr}), VW'({1'b1, 5'd1}));
        for (int i = 1; i < NUM_REGS; i++) tick("clear");

        // Make LLU the last winner, then reset with requests pending
        lu_valid = 1'b1; lu_addr = 5'd4; lu_data = 32'h44;
        #1 chk("lu_solo", VW'(lu_ready), VW'(1'b1));
        tick("lu_solo");
        dbg_valid = 1'b1; dbg_addr = 5'd6; dbg_data = 32'h66;
        rst = 1'b1;
        #1 chk("rst_pending", VW'({lu_ready, dbg_ready}), VW'(2'b00));
        tick("rst_pending");
        rst = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) tick("clear_pending");
        #1 chk("rr_after_rst", VW'({lu_ready, dbg_ready}), VW'(2'b10));
        tick("rr_after_rst");
        idle();

        // Randomized phase, requesters obey the hold-until-ready contract
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!lu_valid && ($urandom_range(0, 2) == 0)) begin
                lu_valid = 1'b1;
                lu_addr  = ($urandom_range(0, 5) == 0) ? '0 : ADDR_W'($urandom);
                lu_data  = $urandom;
            end else if (lu_valid && ($urandom_range(0, 15) == 0)) begin
                lu_valid = 1'b0;
            end
            if (!dbg_valid && ($urandom_range(0, 3) == 0)) begin
                dbg_valid = 1'b1;
                dbg_addr  = ($urandom_range(0, 5) == 0) ? '0 : ADDR_W'($urandom);
                dbg_data  = $urandom;
            end else if (dbg_valid && ($urandom_range(0, 15) == 0)) begin
                dbg_valid = 1'b0;
            end
            if (model_stall()) wb_we = ($urandom_range(0, 7) == 0);
            else               wb_we = ($urandom_range(0, 9) < 6);
            wb_addr = ($urandom_range(0, 5) == 0) ? '0 : ADDR_W'($urandom);
            wb_data = $urandom;
            tick("random");
            if (e_lu_ready)  lu_valid  = 1'b0;
            if (e_dbg_ready) dbg_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
